// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding plus address-check helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ALIGN_OK = 2'b00;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit x DEPTH storage, synchronous write, registered read.
// Ports: clk_i, we, idx, wdata in; rdata out (read-before-write).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle MEM-stage responder: latches a load/store, stalls for LATENCY
// cycles, then pulses ack_o with rdata_o/err_o. Ports: clk_i, rst_i (async
// active-low), MemRead_i, MemWrite_i, addr_i, wdata_i; stall_o, ack_o,
// rdata_o, err_o.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IW = idx_w(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            req;
  logic            fire;
  logic            bad;
  logic [IW-1:0]   idx;
  logic [31:0]     arr_rdata;

  assign req  = MemRead_i | MemWrite_i;
  assign fire = (state == BUSY) && (count == '0);
  assign bad  = (addr_q[1:0] != ALIGN_OK) ||
                ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  // Index follows addr_i while idle so the array read launched on the
  // capture edge is already valid by the completing BUSY cycle.
  assign idx = (state == IDLE) ? addr_i[IW+1:2] : addr_q[IW+1:2];

  assign stall_o = rst_i &
                   (((state == IDLE) & req) | (state == BUSY));

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk_i (clk_i),
    .we    (fire & we_q & ~bad),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      count   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= MemWrite_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            count   <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (fire) begin
            state <= DONE;
            ack_o <= 1'b1;
            err_o <= bad;
            if (bad)        rdata_o <= '0;
            else if (!we_q) rdata_o <= arr_rdata;
          end else begin
            count <= count - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
